// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, drives the instruction ROM and buffers each returned word,
// together with its PC, in a prefetch FIFO that feeds IF/ID over valid/ready.
// Optional build macro FETCH_ALIGN_CHK_EN adds misaligned-redirect trapping:
// an extra output if_adel_o and a FAULT state. Without it, the low two bits of
// redirect targets are cleared.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | first cycle after reset, ROM disabled
//  RUN   | fetching; one push per cycle while the FIFO has room
//  HOLD  | stalled; ROM enabled, no push, FIFO keeps draining
//  FAULT | (FETCH_ALIGN_CHK_EN only) misaligned redirect seen, waits for flush

module inst_fetch_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        if_adel_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
`ifdef FETCH_ALIGN_CHK_EN
        ,
        S_FAULT = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        pc_mem   [FIFO_DEPTH];
    logic [31:0]        inst_mem [FIFO_DEPTH];

    logic               active;
    logic               fifo_full;
    logic               fifo_valid;
    logic               push;
    logic               pop;
    logic               fifo_clr;
    logic [31:0]        flush_tgt;
    logic [31:0]        branch_tgt;
    logic               in_fault;

    // Redirect targets: raw when misalignment is trapped, otherwise word-aligned.
    always_comb begin
`ifdef FETCH_ALIGN_CHK_EN
        flush_tgt  = new_pc_i;
        branch_tgt = branch_pc_i;
`else
        flush_tgt  = new_pc_i & ~32'h3;
        branch_tgt = branch_pc_i & ~32'h3;
`endif
    end

    // FIFO status and the IF/ID handshake; an empty FIFO never reports valid.
    always_comb begin
        active     = (state_q == S_RUN) || (state_q == S_HOLD);
        fifo_valid = (count_q != '0);
        fifo_full  = (count_q == DEPTH_C);
        pop        = fifo_valid && if_ready_i;
`ifdef FETCH_ALIGN_CHK_EN
        in_fault   = (state_q == S_FAULT);
`else
        in_fault   = 1'b0;
`endif
    end

    // FSM state register and fetch PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next state, next fetch PC, push/clear decisions; flush beats branch beats stall.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fifo_clr   = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN, S_HOLD: begin
                state_d = stall_i ? S_HOLD : S_RUN;
                if (flush_i) begin
                    fifo_clr   = 1'b1;
                    fetch_pc_d = flush_tgt;
`ifdef FETCH_ALIGN_CHK_EN
                    if (flush_tgt[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end
`endif
                end else if (branch_i) begin
                    fifo_clr   = 1'b1;
                    fetch_pc_d = branch_tgt;
`ifdef FETCH_ALIGN_CHK_EN
                    if (branch_tgt[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end
`endif
                end else if ((state_q == S_RUN) && !stall_i && (!fifo_full || pop)) begin
                    // A full FIFO still accepts a word when the head leaves this cycle.
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
`ifdef FETCH_ALIGN_CHK_EN
            S_FAULT: begin
                // Branches are ignored here; only an aligned flush recovers.
                if (flush_i) begin
                    fetch_pc_d = flush_tgt;
                    if (flush_tgt[1:0] == 2'b00) begin
                        state_d = stall_i ? S_HOLD : S_RUN;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; a redirect discards everything, including a same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the slot is marked valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= rom_inst_i;
        end
    end

    // ROM interface and IF/ID outputs; stale slot data is masked to zero.
    always_comb begin
        rom_ce_o   = active;
        rom_addr_o = active ? fetch_pc_q : 32'h0;
        if_valid_o = fifo_valid;
        if_pc_o    = fifo_valid ? pc_mem[rd_ptr_q]   : 32'h0;
        if_inst_o  = fifo_valid ? inst_mem[rd_ptr_q] : 32'h0;
        if (in_fault) begin
            if_pc_o = fetch_pc_q;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    // Address-error flag presented to IF/ID while trapped.
    always_comb begin
        if_adel_o = in_fault;
    end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
`ifdef FETCH_ALIGN_CHK_EN
    logic        if_adel_o;
`endif

    int nerr = 0;
    int nchk = 0;

    inst_fetch_ctrl #(.FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .new_pc_i    (new_pc_i),
        .branch_i    (branch_i),
        .branch_pc_i (branch_pc_i),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_inst_i  (rom_inst_i),
        .if_valid_o  (if_valid_o),
        .if_ready_i  (if_ready_i),
        .if_pc_o     (if_pc_o),
        .if_inst_o   (if_inst_o)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .if_adel_o   (if_adel_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] exp_pc);
        chk({tag, "_valid"}, {31'h0, if_valid_o}, 32'h1);
        chk({tag, "_pc"},    if_pc_o,             exp_pc);
        chk({tag, "_inst"},  if_inst_o,           rom_word(exp_pc));
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!if_valid_o && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, {31'h0, if_valid_o}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = 32'h0;
        branch_i = 1'b0; branch_pc_i = 32'h0; if_ready_i = 1'b1;
        #2;
        chk("rst_ce",    {31'h0, rom_ce_o},   32'h0);
        chk("rst_addr",  rom_addr_o,          32'h0);
        chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
        chk("rst_pc",    if_pc_o,             32'h0);
        chk("rst_inst",  if_inst_o,           32'h0);
        #10 rst = 1'b0;

        // 1: release, sequential fetch with ready=1
        tick();
        chk("t1_ce",    {31'h0, rom_ce_o},   32'h1);
        chk("t1_addr0", rom_addr_o,          32'h0);
        chk("t1_novalid", {31'h0, if_valid_o}, 32'h0);
        tick(); chk_head("t1_h0", 32'h0);
        tick(); chk_head("t1_h4", 32'h4);
        tick(); chk_head("t1_h8", 32'h8);
        chk("t1_addr", rom_addr_o, 32'hC);

        // 6: asynchronous reset mid-burst
        #2 rst = 1'b1;
        #1;
        chk("t6_ce",    {31'h0, rom_ce_o},   32'h0);
        chk("t6_addr",  rom_addr_o,          32'h0);
        chk("t6_valid", {31'h0, if_valid_o}, 32'h0);
        chk("t6_pc",    if_pc_o,             32'h0);
        chk("t6_inst",  if_inst_o,           32'h0);
        if_ready_i = 1'b0;
        #4 rst = 1'b0;

        // 2: back-pressure fills the FIFO, fetch PC holds at 0x10
        tick();
        chk("t2_ce", {31'h0, rom_ce_o}, 32'h1);
        for (int i = 0; i < 8; i++) tick();
        chk("t2_hold", rom_addr_o, 32'h10);
        if_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_head("t2_drain", 32'(4 * i));
            tick();
        end
        chk_head("t2_h18", 32'h18);

        // 5: stall drains the FIFO with fetch frozen
        stall_i = 1'b1;
        tick(); chk_head("t5_h1c", 32'h1C);
        chk("t5_frozen", rom_addr_o, 32'h28);
        tick(); chk_head("t5_h20", 32'h20);
        tick(); chk_head("t5_h24", 32'h24);
        tick(); chk("t5_empty", {31'h0, if_valid_o}, 32'h0);
        tick(); chk("t5_empty2", {31'h0, if_valid_o}, 32'h0);
        chk("t5_addr", rom_addr_o, 32'h28);
        chk("t5_ce",   {31'h0, rom_ce_o}, 32'h1);
        stall_i = 1'b0;
        wait_valid("t5_resume", 4);
        chk_head("t5_h28", 32'h28);

        // 3: branch discards three queued entries
        if_ready_i = 1'b0;
        tick(); tick();
        chk_head("t3_held", 32'h28);
        chk("t3_addr", rom_addr_o, 32'h34);
        branch_i = 1'b1; branch_pc_i = 32'h100; if_ready_i = 1'b1;
        tick();
        branch_i = 1'b0;
        chk("t3_bubble", {31'h0, if_valid_o}, 32'h0);
        chk("t3_addr2",  rom_addr_o, 32'h100);
        tick(); chk_head("t3_h100", 32'h100);
        tick(); chk_head("t3_h104", 32'h104);

        // 4: flush beats branch
        flush_i = 1'b1; new_pc_i = 32'h20; branch_i = 1'b1; branch_pc_i = 32'h100;
        tick();
        flush_i = 1'b0; branch_i = 1'b0;
        chk("t4_bubble", {31'h0, if_valid_o}, 32'h0);
        chk("t4_addr",   rom_addr_o, 32'h20);
        tick(); chk_head("t4_h20", 32'h20);

        // misaligned branch target
        branch_i = 1'b1; branch_pc_i = 32'h102;
        tick();
        branch_i = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chk("t6a_adel",  {31'h0, if_adel_o},  32'h1);
        chk("t6a_pc",    if_pc_o,             32'h102);
        chk("t6a_ce",    {31'h0, rom_ce_o},   32'h0);
        chk("t6a_valid", {31'h0, if_valid_o}, 32'h0);
        tick(); tick();
        chk("t6a_adel2", {31'h0, if_adel_o},  32'h1);
        chk("t6a_pc2",   if_pc_o,             32'h102);
        flush_i = 1'b1; new_pc_i = 32'h40;
        tick();
        flush_i = 1'b0;
        chk("t6a_clr",   {31'h0, if_adel_o},  32'h0);
        chk("t6a_ce2",   {31'h0, rom_ce_o},   32'h1);
        chk("t6a_addr",  rom_addr_o,          32'h40);
        tick(); chk_head("t6a_h40", 32'h40);
`else
        chk("mis_valid", {31'h0, if_valid_o}, 32'h0);
        chk("mis_addr",  rom_addr_o,          32'h100);
        tick(); chk_head("mis_h100", 32'h100);
`endif

        // PC wrap at the top of the address space
        branch_i = 1'b1; branch_pc_i = 32'hFFFF_FFFC;
        tick();
        branch_i = 1'b0;
        tick(); chk_head("wrap_top", 32'hFFFF_FFFC);
        tick(); chk_head("wrap_zero", 32'h0);

        // branch while stalled still redirects
        stall_i = 1'b1; branch_i = 1'b1; branch_pc_i = 32'h200;
        tick();
        branch_i = 1'b0;
        chk("bs_addr",  rom_addr_o,          32'h200);
        chk("bs_valid", {31'h0, if_valid_o}, 32'h0);
        tick();
        chk("bs_nopush", {31'h0, if_valid_o}, 32'h0);
        stall_i = 1'b0;
        wait_valid("bs_resume", 4);
        chk_head("bs_h200", 32'h200);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
